seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Keeps the 12 base operations and their encoding, registered with 1-cycle latency.
- Adds iterative RV32M/RV64M multiply/divide/remainder as a multi-cycle state machine.
- Sits between the operand muxes and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- SHW, $clog2(XLEN), shift-amount width. Derived; do not override.
- ERR_VAL, 32'hDEADBEEF zero-extended to XLEN, result for an undefined opcode.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- aluop  in  5  operation select (encoding below).
- opa  in  XLEN  operand A (formerly alumux1_out).
- opb  in  XLEN  operand B (formerly alumux2_out).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- aluout  out  XLEN  result.
- op_err  out  1  qualifies aluout; high when the accepted opcode was undefined.
- busy  out  1  iterative operation in progress.

Behaviour:
- Opcode encoding:
  - 0 addspecial: (a+b) & ~1.
  - 1 add, 2 sub, 3 and, 4 or, 5 xor.
  - 6 sll, 7 srl, 8 sra, all using b[SHW-1:0].
  - 9 pass b.
  - 10 slt (signed), 11 sltu; zero-extended 0/1.
  - 12 mul (low XLEN), 13 mulh (s×s), 14 mulhsu (a signed × b unsigned), 15 mulhu.
  - 16 div, 17 divu, 18 rem, 19 remu.
  - 20-31: ERR_VAL with op_err=1.
- Reset (async, rst_n=0): state IDLE; aluout=0; out_valid=0; op_err=0; busy=0; iteration counter=0.
- Reset mid-operation discards the result; no output is produced after release.
- States:
  - IDLE: in_ready=1. On in_valid, capture operands and opcode. Base/undefined op → DONE, with aluout computed at the same edge. Opcodes 12-19 → BUSY, with counter=XLEN.
  - BUSY: in_ready=0, busy=1. One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide. Counter decrements each cycle; at counter==1 the final step writes aluout and moves to DONE.
  - DONE: out_valid=1. aluout and op_err are held stable until out_ready=1. in_ready=out_ready.
  - DONE exit: out_ready with in_valid accepts the next request in the same cycle (back-to-back, no bubble). out_ready without in_valid → IDLE.
- Latency, measured from the accept edge N:
  - Base ops: out_valid at cycle N+1.
  - Mul/div: out_valid at cycle N+1+XLEN.
  - Sustained throughput for base ops: 1 per cycle.
- Signed mul/div convert operands to magnitudes at accept and fix the result sign in the final step.
- Divide by zero: div/divu quotient = all ones; rem/remu = dividend. Full XLEN cycles are still taken.
- Signed overflow (a = most-negative, b = -1): div → most-negative; rem → 0.
- in_valid while in_ready=0 is ignored. Operands need only be valid on the accept edge.
- out_valid, aluout and op_err never change while out_valid=1 && out_ready=0.

Optional Feature:
- Macro SEQ_ALU_MULDIV_EN.
- Defined: opcodes 12-19 behave as above.
- Undefined: the BUSY state, counter and multiply/divide datapath are not compiled. Opcodes 12-19 are treated as undefined: ERR_VAL with op_err=1 and 1-cycle latency. busy is tied to 0.

Test Plan:
- Reset then base ops, XLEN=32, out_ready=1, in_valid held high:
  - add 7+5 → aluout=12 at N+1.
  - addspecial 3+4 → 6.
  - sra 0x80000000 by 4 → 0xF8000000.
  - slt -1<1 → 1.
  - sltu 0xFFFFFFFF<1 → 0.
  - Expect out_valid on every cycle with no bubbles.
- Multiply, XLEN=32:
  - mul 0xFFFFFFFF × 3 → 0xFFFFFFFD.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulh -2 × 3 → 0xFFFFFFFF.
  - For each: out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
- Divide corner cases:
  - div -7/2 → 0xFFFFFFFD; rem -7/2 → 0xFFFFFFFF.
  - divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5.
  - div 0x80000000/-1 → 0x80000000; rem 0x80000000/-1 → 0.
- Backpressure: out_ready=0 for 5 cycles after xor 0xF0^0xFF → aluout=0x0F held stable, in_ready=0. Then out_ready=1 with in_valid (or 1|2) → both accepted; aluout=3 one cycle later.
- Undefined opcode and reset:
  - aluop=25 → aluout=0xDEADBEEF, op_err=1.
  - Assert rst_n=0 mid-div, at cycle 10 → outputs 0 immediately; no out_valid after release.
- Build without SEQ_ALU_MULDIV_EN: mul 2×3 → 0xDEADBEEF, op_err=1 at N+1; busy never asserted.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked, registered ALU with the 12 base operations at 1-cycle latency.
// Define SEQ_ALU_MULDIV_EN to add iterative RV32M/RV64M multiply/divide (opcodes 12-19).
module seq_alu #(
    parameter int              XLEN    = 32,
    parameter int              SHW     = $clog2(XLEN),
    parameter logic [XLEN-1:0] ERR_VAL = XLEN'(32'hDEADBEEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      aluop,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            op_err,
    output logic            busy
);

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t          state, state_n, accept_state;
    logic            accept, is_md, md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN:0]   base_res;

    function automatic logic [XLEN:0] base_op(input logic [4:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            err;
        err = 1'b0;
        case (op)
            5'd0:    r = (a + b) & ~XLEN'(1);
            5'd1:    r = a + b;
            5'd2:    r = a - b;
            5'd3:    r = a & b;
            5'd4:    r = a | b;
            5'd5:    r = a ^ b;
            5'd6:    r = a << b[SHW-1:0];
            5'd7:    r = a >> b[SHW-1:0];
            5'd8:    r = $unsigned($signed(a) >>> b[SHW-1:0]);
            5'd9:    r = b;
            5'd10:   r = XLEN'($signed(a) < $signed(b));
            5'd11:   r = XLEN'(a < b);
            default: begin
                r   = ERR_VAL;
                err = 1'b1;
            end
        endcase
        return {err, r};
    endfunction

    assign accept   = in_valid && in_ready;
    assign base_res = base_op(aluop, opa, opb);

`ifdef SEQ_ALU_MULDIV_EN
    localparam int CNT_W = SHW + 1;

    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, opnd, hi_n, lo_n, diff, mag_a, mag_b;
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [2*XLEN-1:0] prod;
    logic [4:0]        md_op;
    logic              neg, ge, a_neg, b_neg;

    assign is_md        = aluop inside {[5'd12:5'd19]};
    assign accept_state = is_md ? BUSY : DONE;
    assign md_done      = (state == BUSY) && (cnt == CNT_W'(1));
    assign a_neg        = (aluop inside {5'd13, 5'd14, 5'd16, 5'd18}) && opa[XLEN-1];
    assign b_neg        = (aluop inside {5'd13, 5'd16, 5'd18}) && opb[XLEN-1];
    assign mag_a        = a_neg ? -opa : opa;
    assign mag_b        = b_neg ? -opb : opb;

    // Multiply: hi accumulates, lo is the multiplier consumed LSB-first.
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh  = {hi, lo[XLEN-1]};
        diff    = rem_sh[XLEN-1:0] - opnd;
        ge      = rem_sh >= {1'b0, opnd};
        if (md_op inside {[5'd12:5'd15]}) begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end else begin
            hi_n = ge ? diff : rem_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end
        prod = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        case (md_op)
            5'd12:               md_result = prod[XLEN-1:0];
            5'd13, 5'd14, 5'd15: md_result = prod[2*XLEN-1:XLEN];
            5'd16, 5'd17:        md_result = neg ? -lo_n : lo_n;
            default:             md_result = neg ? -hi_n : hi_n;
        endcase
    end

    // A zero divisor keeps the quotient positive so it stays all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            neg   <= 1'b0;
            md_op <= '0;
        end else if (accept && is_md) begin
            cnt   <= CNT_W'(XLEN);
            md_op <= aluop;
            hi    <= '0;
            if (aluop inside {[5'd12:5'd15]}) begin
                lo   <= mag_b;
                opnd <= mag_a;
                neg  <= a_neg ^ b_neg;
            end else begin
                lo   <= mag_a;
                opnd <= mag_b;
                neg  <= (aluop inside {5'd16, 5'd17}) ? ((a_neg ^ b_neg) && (opb != '0)) : a_neg;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
            hi  <= hi_n;
            lo  <= lo_n;
        end
    end
`else
    assign is_md        = 1'b0;
    assign accept_state = DONE;
    assign md_done      = 1'b0;
    assign md_result    = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = accept_state;
`ifdef SEQ_ALU_MULDIV_EN
            BUSY: if (cnt == CNT_W'(1)) state_n = DONE;
`endif
            DONE: if (out_ready) state_n = in_valid ? accept_state : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
`ifdef SEQ_ALU_MULDIV_EN
            BUSY: busy = 1'b1;
`endif
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout <= '0;
            op_err <= 1'b0;
        end else if (accept && !is_md) begin
            aluout <= base_res[XLEN-1:0];
            op_err <= base_res[XLEN];
        end else if (md_done) begin
            aluout <= md_result;
            op_err <= 1'b0;
        end
    end

endmodule
